// File: rtl/alu_seq_if.sv
// Operation request/result bundle between the register-file read stage and alu_seq.
// The master drives operands and the opcode; the slave returns the result and PSR status.
`timescale 1ns/1ps
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             I_VALID;
   logic             O_READY;
   logic [3:0]       I_OPCODE;
   logic [WIDTH-1:0] I_A;
   logic [WIDTH-1:0] I_B;
   logic             I_CARRY;
   logic             O_VALID;
   logic [WIDTH-1:0] O_C;
   logic [4:0]       O_STATUS;

   modport master (
      output I_VALID, I_OPCODE, I_A, I_B, I_CARRY,
      input  O_READY, O_VALID, O_C, O_STATUS
   );

   modport slave (
      input  I_VALID, I_OPCODE, I_A, I_B, I_CARRY,
      output O_READY, O_VALID, O_C, O_STATUS
   );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: logic/arith/shift ops return in one cycle, MUL iterates one bit per cycle.
// Defining ALU_SEQ_DIV_EN adds a bit-serial unsigned restoring divider on opcode 12.
`timescale 1ns/1ps
module alu_seq #(
   parameter int WIDTH = 16
) (
   input logic      I_CLK,
   input logic      I_RESET,
   alu_seq_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
   localparam logic [SHW-1:0]   LAST_CNT = SHW'(WIDTH - 1);
   localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADDC = 4'd1,  OP_MUL  = 4'd2,  OP_SUB  = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4,  OP_AND  = 4'd5,  OP_OR   = 4'd6,  OP_XOR  = 4'd7;
   localparam logic [3:0] OP_LSH  = 4'd8,  OP_RSH  = 4'd9,  OP_ALSH = 4'd10, OP_ARSH = 4'd11;
`ifdef ALU_SEQ_DIV_EN
   localparam logic [3:0] OP_DIV  = 4'd12;
`endif

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t               state_q, state_d;
   logic [SHW-1:0]       cnt_q, cnt_d;
   logic                 valid_q, valid_d;
   logic [WIDTH-1:0]     c_q, c_d;
   logic [4:0]           status_q, status_d;
   logic [2*WIDTH-1:0]   opa_q, opa_d, acc_q, acc_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   mul_acc, mul_prod;
   logic                 mul_f;
   logic [WIDTH+4:0]     single;
`ifdef ALU_SEQ_DIV_EN
   logic                 isdiv_q, isdiv_d, divz_q, divz_d;
   logic [WIDTH:0]       div_rem, div_rem_n;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_quo;
`endif

   // Returns {N,Z,F,L,C,result}; unknown opcodes yield all zeros.
   function automatic logic [WIDTH+4:0] alu_single(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b, input logic cin);
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] res;
      logic             fc, fl, ff, fn, big, undef;
      sum   = '0;
      res   = '0;
      fc    = 1'b0;
      fl    = 1'b0;
      ff    = 1'b0;
      undef = 1'b0;
      big   = (b >= WIDTH_V);
      case (op)
         OP_ADD, OP_ADDC: begin
            sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADDC) & cin};
            res = sum[WIDTH-1:0];
            fc  = sum[WIDTH];
            ff  = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res = b - a;
            fl  = (b < a);
            ff  = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != b[WIDTH-1]);
         end
         OP_NOT:          res = ~a;
         OP_AND:          res = a & b;
         OP_OR:           res = a | b;
         OP_XOR:          res = a ^ b;
         OP_LSH, OP_ALSH: res = big ? '0 : (a << b[SHW-1:0]);
         OP_RSH:          res = big ? '0 : (a >> b[SHW-1:0]);
         OP_ARSH:         res = big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> b[SHW-1:0]);
         default:         undef = 1'b1;
      endcase
      fn = (op == OP_SUB) ? ($signed(b) < $signed(a)) : res[WIDTH-1];
      return undef ? '0 : {fn, (res == '0), ff, fl, fc, res};
   endfunction

   // Shift-add on magnitudes: opa holds the shifting multiplicand, opb the remaining multiplier bits.
   assign mul_acc  = acc_q + (opb_q[0] ? opa_q : '0);
   assign mul_prod = neg_q ? -mul_acc : mul_acc;
   assign mul_f    = ~(&mul_prod[2*WIDTH-1:WIDTH-1] | ~|mul_prod[2*WIDTH-1:WIDTH-1]);
   assign single   = alu_single(bus.I_OPCODE, bus.I_A, bus.I_B, bus.I_CARRY);

`ifdef ALU_SEQ_DIV_EN
   // Restoring step: remainder lives in acc, dividend bits shift out of opb as quotient bits shift in.
   assign div_rem   = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
   assign div_ge    = (div_rem >= {1'b0, opa_q[WIDTH-1:0]});
   assign div_rem_n = div_ge ? (div_rem - {1'b0, opa_q[WIDTH-1:0]}) : div_rem;
   assign div_quo   = {opb_q[WIDTH-2:0], div_ge};
`endif

   assign bus.O_READY  = (state_q == S_IDLE);
   assign bus.O_VALID  = valid_q;
   assign bus.O_C      = c_q;
   assign bus.O_STATUS = status_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      valid_d  = 1'b0;
      c_d      = c_q;
      status_d = status_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
`ifdef ALU_SEQ_DIV_EN
      isdiv_d  = isdiv_q;
      divz_d   = divz_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.I_VALID) begin
               if (bus.I_OPCODE == OP_MUL) begin
                  opa_d   = {{WIDTH{1'b0}}, (bus.I_A[WIDTH-1] ? -bus.I_A : bus.I_A)};
                  opb_d   = bus.I_B[WIDTH-1] ? -bus.I_B : bus.I_B;
                  neg_d   = bus.I_A[WIDTH-1] ^ bus.I_B[WIDTH-1];
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = S_BUSY;
`ifdef ALU_SEQ_DIV_EN
                  isdiv_d = 1'b0;
               end else if (bus.I_OPCODE == OP_DIV) begin
                  opa_d   = {{WIDTH{1'b0}}, bus.I_A};
                  opb_d   = bus.I_B;
                  divz_d  = (bus.I_A == '0);
                  isdiv_d = 1'b1;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = S_BUSY;
`endif
               end else begin
                  {status_d, c_d} = single;
                  valid_d         = 1'b1;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
            acc_d = mul_acc;
`ifdef ALU_SEQ_DIV_EN
            if (isdiv_q) begin
               opb_d = div_quo;
               acc_d = {{(WIDTH-1){1'b0}}, div_rem_n};
            end
`endif
            if (cnt_q == LAST_CNT) begin
               state_d  = S_IDLE;
               valid_d  = 1'b1;
               c_d      = mul_prod[WIDTH-1:0];
               status_d = {mul_prod[WIDTH-1], (mul_prod[WIDTH-1:0] == '0), mul_f, 2'b00};
`ifdef ALU_SEQ_DIV_EN
               if (isdiv_q) begin
                  c_d      = div_quo;
                  status_d = {div_quo[WIDTH-1], (div_quo == '0), divz_q, 2'b00};
               end
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         c_q      <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         c_q      <= c_d;
         status_q <= status_d;
      end
   end

   always_ff @(posedge I_CLK) begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
`ifdef ALU_SEQ_DIV_EN
      isdiv_q <= isdiv_d;
      divz_q  <= divz_d;
`endif
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq (WIDTH=16) against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;
   localparam int W = 16;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   alu_seq_if #(.WIDTH(W)) bus_if ();
   alu_seq #(.WIDTH(W)) dut (.I_CLK(clk), .I_RESET(rst), .bus(bus_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {N,Z,F,L,C,result} from integer arithmetic on the operand values.
   function automatic logic [20:0] model(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
      int     sa, sb, t;
      longint p, d, q;
      logic [15:0] r;
      logic c, l, f, n;
      bit undef;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r = '0; c = 1'b0; l = 1'b0; f = 1'b0; undef = 1'b0; t = 0; p = 0; d = 1; q = 0;
      case (op)
         4'd0, 4'd1: begin
            t = int'(a) + int'(b) + ((op == 4'd1) ? int'(cin) : 0);
            r = t[15:0];
            c = (t > 65535);
            t = sa + sb + ((op == 4'd1) ? int'(cin) : 0);
            f = (t > 32767) || (t < -32768);
         end
         4'd2: begin
            p = longint'(sa) * longint'(sb);
            r = p[15:0];
            f = (p > 32767) || (p < -32768);
         end
         4'd3: begin
            t = sb - sa;
            r = t[15:0];
            l = (int'(b) < int'(a));
            f = (t > 32767) || (t < -32768);
         end
         4'd4: r = ~a;
         4'd5: r = a & b;
         4'd6: r = a | b;
         4'd7: r = a ^ b;
         4'd8, 4'd10: begin
            if (b < 16'd16) begin
               p = longint'(a) * (longint'(1) << b);
               r = p[15:0];
            end
         end
         4'd9: begin
            if (b < 16'd16) begin
               p = longint'(a) / (longint'(1) << b);
               r = p[15:0];
            end
         end
         4'd11: begin
            if (b >= 16'd16) r = a[15] ? 16'hFFFF : 16'h0000;
            else begin
               d = longint'(1) << b;
               q = longint'(sa) / d;
               if (sa < 0 && (longint'(sa) % d) != 0) q = q - 1;
               r = q[15:0];
            end
         end
`ifdef ALU_SEQ_DIV_EN
         4'd12: begin
            if (a == 16'h0) begin r = 16'hFFFF; f = 1'b1; end
            else r = b / a;
         end
`endif
         default: undef = 1'b1;
      endcase
      n = (op == 4'd3) ? (sb < sa) : r[15];
      if (undef) return '0;
      return {n, (r == 16'h0), f, l, c, r};
   endfunction

   function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
      if (op == 4'd12) return W + 1;
`endif
      return (op == 4'd2) ? W + 1 : 1;
   endfunction

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin);
      bus_if.I_VALID  = v;
      bus_if.I_OPCODE = op;
      bus_if.I_A      = a;
      bus_if.I_B      = b;
      bus_if.I_CARRY  = cin;
   endtask

   // Issue one op, wait (bounded) for O_VALID, check latency, result, status and ready.
   task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input bit poke, input string tag);
      logic [20:0] m;
      int lat, busy_lo;
      m = model(op, a, b, cin);
      drive(1'b1, op, a, b, cin);
      @(posedge clk); #1;
      drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
      lat = 1;
      busy_lo = 0;
      while (!bus_if.O_VALID && lat < 40) begin
         if (!bus_if.O_READY) busy_lo++;
         if (poke && lat == 3) drive(1'b1, 4'd0, 16'h1111, 16'h2222, 1'b0);
         else drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
         @(posedge clk); #1;
         lat++;
      end
      drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(op)));
      chk({tag, "_c"}, 32'(bus_if.O_C), 32'(m[15:0]));
      chk({tag, "_st"}, 32'(bus_if.O_STATUS), 32'(m[20:16]));
      chk({tag, "_rdy"}, 32'(bus_if.O_READY), 32'd1);
      if (poke) begin
         chk({tag, "_busylo"}, 32'(busy_lo), 32'(W));
         @(posedge clk); #1;
         chk({tag, "_drop"}, 32'(bus_if.O_VALID), 32'd0);
      end
   endtask

   initial begin
      logic [20:0] m1, m2;
      logic [3:0]  rop;
      logic [15:0] ra, rb;
      int pulses;
      drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", 32'(bus_if.O_READY), 32'd1);
      chk("rst_valid", 32'(bus_if.O_VALID), 32'd0);
      chk("rst_c", 32'(bus_if.O_C), 32'd0);
      chk("rst_status", 32'(bus_if.O_STATUS), 32'd0);

      run_op(4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
      chk("add_ovf_lit", 32'({bus_if.O_STATUS, bus_if.O_C}), 32'({5'b10100, 16'h8000}));
      run_op(4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
      chk("add_wrap_lit", 32'(bus_if.O_STATUS), 32'(5'b01001));
      run_op(4'd1, 16'h0001, 16'h0002, 1'b1, 1'b0, "addc");
      run_op(4'd3, 16'h0005, 16'h0003, 1'b0, 1'b0, "sub_neg");
      chk("sub_neg_lit", 32'(bus_if.O_C), 32'h0000FFFE);
      run_op(4'd3, 16'h8000, 16'h8000, 1'b0, 1'b0, "sub_eq");
      run_op(4'd2, 16'hFFFD, 16'h0007, 1'b0, 1'b1, "mul_neg");
      chk("mul_neg_lit", 32'(bus_if.O_C), 32'h0000FFEB);
      run_op(4'd2, 16'h0100, 16'h0100, 1'b0, 1'b0, "mul_ovf");
      run_op(4'd2, 16'h8000, 16'hFFFF, 1'b0, 1'b0, "mul_min");
      run_op(4'd11, 16'h8001, 16'd4, 1'b0, 1'b0, "arsh4");
      chk("arsh4_lit", 32'(bus_if.O_C), 32'h0000F800);
      run_op(4'd9, 16'h8001, 16'd16, 1'b0, 1'b0, "rsh16");
      run_op(4'd11, 16'h8001, 16'd20, 1'b0, 1'b0, "arsh20");
      run_op(4'd8, 16'h8001, 16'd1, 1'b0, 1'b0, "lsh1");
      run_op(4'd10, 16'h8001, 16'd15, 1'b0, 1'b0, "alsh15");
      run_op(4'd4, 16'h00FF, 16'h1234, 1'b0, 1'b0, "not");
      run_op(4'd12, 16'd7, 16'd100, 1'b0, 1'b0, "op12");
      run_op(4'd12, 16'd0, 16'd100, 1'b0, 1'b0, "op12_a0");
      run_op(4'd14, 16'h1234, 16'h5678, 1'b1, 1'b0, "undef14");

      // Back-to-back single-cycle ops.
      m1 = model(4'd0, 16'd10, 16'd20, 1'b0);
      m2 = model(4'd7, 16'h0F0F, 16'h00FF, 1'b0);
      drive(1'b1, 4'd0, 16'd10, 16'd20, 1'b0);
      @(posedge clk); #1;
      drive(1'b1, 4'd7, 16'h0F0F, 16'h00FF, 1'b0);
      chk("b2b_v1", 32'(bus_if.O_VALID), 32'd1);
      chk("b2b_c1", 32'(bus_if.O_C), 32'(m1[15:0]));
      @(posedge clk); #1;
      drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
      chk("b2b_v2", 32'(bus_if.O_VALID), 32'd1);
      chk("b2b_c2", 32'(bus_if.O_C), 32'(m2[15:0]));
      @(posedge clk); #1;
      chk("b2b_v3", 32'(bus_if.O_VALID), 32'd0);

      // Reset in the middle of a MUL aborts it silently.
      run_op(4'd6, 16'h00F0, 16'h0F00, 1'b0, 1'b0, "or_pre");
      drive(1'b1, 4'd2, 16'd3, 16'd5, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rmid_ready", 32'(bus_if.O_READY), 32'd1);
      chk("rmid_valid", 32'(bus_if.O_VALID), 32'd0);
      chk("rmid_c", 32'(bus_if.O_C), 32'd0);
      chk("rmid_status", 32'(bus_if.O_STATUS), 32'd0);
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus_if.O_VALID) pulses++;
      end
      chk("rmid_nopulse", 32'(pulses), 32'd0);

      // Reset wins over a simultaneous request.
      rst = 1'b1;
      drive(1'b1, 4'd0, 16'd1, 16'd1, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
      chk("rstv_valid", 32'(bus_if.O_VALID), 32'd0);
      @(posedge clk); #1;
      chk("rstv_valid2", 32'(bus_if.O_VALID), 32'd0);
      chk("rstv_c", 32'(bus_if.O_C), 32'd0);

      // Randomized ops.
      for (int i = 0; i < 60; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         if (rop >= 4'd8 && rop <= 4'd11 && $urandom_range(0, 3) != 0) rb = 16'($urandom_range(0, 20));
         run_op(rop, ra, rb, 1'($urandom), 1'b0, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
